mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, width of address and data buses.
REQ-002 Parameter: STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits (range 1..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held until if_ready.
REQ-006 if_addr  in  ADDR_W  fetch address; stable while if_req.
REQ-007 if_rdata  out  ADDR_W  fetch read data; valid when if_ready.
REQ-008 if_ready  out  1  fetch completion strobe, one cycle.
REQ-009 d_req  in  1  load/store request; held until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  ADDR_W  data address.
REQ-012 d_wdata  in  ADDR_W  store data.
REQ-013 d_wmask  in  4  store byte enables.
REQ-014 d_rdata  out  ADDR_W  load data; valid when d_ready.
REQ-015 d_ready  out  1  data completion strobe, one cycle.
REQ-016 mem_req  out  1  request to the unified memory, registered.
REQ-017 mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/ADDR_W/4  registered request fields.
REQ-018 mem_rdata  in  ADDR_W  memory read data; valid with mem_ack.
REQ-019 mem_ack  in  1  memory completion, one cycle, any latency >= 0 cycles after mem_req rises.

Function
REQ-020 FSM states IDLE, BUSY_I, BUSY_D; only IDLE arbitrates.
REQ-021 IDLE, no request: remain in IDLE; mem_req = 0.
REQ-022 IDLE, d_req only: latch the d_* fields into the mem_* registers, go to BUSY_D.
REQ-023 IDLE, if_req only: latch if_addr, mem_we = 0, mem_wmask = 0, go to BUSY_I.
REQ-024 IDLE, both requests: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-025 starve_cnt increments, saturating at STARVE_LIMIT, on each data grant made while if_req = 1.
REQ-026 starve_cnt clears on every fetch grant; it holds otherwise.
REQ-027 BUSY_x: mem_req = 1 and all mem_* fields are held constant until mem_ack.
REQ-028 BUSY_x with mem_ack: ready for x = mem_ack combinationally, rdata = mem_rdata in the same cycle, next state IDLE.
REQ-029 In BUSY_I, d_ready = 0; in BUSY_D, if_ready = 0; ready is never asserted outside BUSY states.
REQ-030 Stores also complete only on mem_ack; d_rdata on a store is don't-care.
REQ-031 Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, ready at N+1 if mem_ack is immediate; one IDLE turnaround cycle between transactions.
REQ-032 Requests arriving during BUSY_x wait; requester fields are sampled only at grant, so changing fields after grant does not affect the transaction in flight.
REQ-033 mem_ack while in IDLE is ignored.
REQ-034 if_rdata and d_rdata = 0 whenever the matching ready is 0.

Reset
REQ-035 reset = 1 forces IDLE, starve_cnt = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 0.
REQ-036 Reset mid-transaction abandons it: no ready pulse is issued, and mem_req drops on the next edge.
REQ-037 reset has priority over every request and mem_ack in the same cycle.

Structure
REQ-038 State encodings (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the STARVE_LIMIT default live in the shared CPU package/header used by the pipeline.
REQ-039 One sub-module: arb_starve_counter (saturating counter with inc/clr/at_limit); all other logic is inline.
REQ-040 Size target: 150-250 lines RTL.

Verification
REQ-041 Fetch only, if_addr=0x0000_0010, mem_ack 2 cycles after mem_req -> mem_addr=0x10, mem_we=0; if_ready for 1 cycle with if_rdata=mem_rdata=0x0000_0513.
REQ-042 if_req and d_req simultaneous, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, wmask=4'hF -> data granted first, fetch granted next after one IDLE cycle.
REQ-043 d_req and if_req held continuously, STARVE_LIMIT=4, zero-latency ack -> grant sequence D,D,D,D,I repeating; no fetch wait exceeds 4 data grants.
REQ-044 Reset asserted in BUSY_D before mem_ack -> next cycle IDLE with mem_req=0; no d_ready pulse; starve_cnt=0.
REQ-045 mem_ack pulsed in IDLE with no request -> no ready pulse, no state change.
REQ-046 Random memory latency 0..7 with random requests -> every request completes exactly once; mem_* stable during BUSY; addresses match the granted requester.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// The state encodings and the starvation limit default are used across the CPU pipeline.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam int STARVE_LIMIT_DEFAULT = 4;
   localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants made while a fetch was waiting.
// at_limit tells the arbiter that fetch must win the next contested grant.
module arb_starve_counter
   import mem_arbiter_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

   logic [STARVE_CNT_W-1:0] cnt;

   // Clear takes priority over increment; saturate instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT_V)) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      at_limit = (cnt == LIMIT_V);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one unified memory port.
// Data normally wins; fetch is guaranteed a grant after STARVE_LIMIT contested data grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [ADDR_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [ADDR_W-1:0] d_wdata,
   input  logic [3:0]        d_wmask,
   output logic [ADDR_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic [ADDR_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   arb_state_t state, state_nxt;
   logic       grant_i;
   logic       grant_d;
   logic       starve_at_limit;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (grant_d & if_req),
      .clr      (grant_i),
      .at_limit (starve_at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Only IDLE arbitrates; a busy state waits for the memory acknowledge.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(if_req && starve_at_limit)) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (if_req) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Requester fields are captured only at grant, so they stay frozen until the acknowledge.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if (grant_d) begin
         mem_req   <= 1'b1;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
         mem_wmask <= d_wmask;
      end else if (grant_i) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= if_addr;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else if ((state != IDLE) && mem_ack) begin
         mem_req   <= 1'b0;
      end
   end

   // Reset abandons a transaction in flight, so it also suppresses the completion strobe.
   always_comb begin
      if_ready = (state == BUSY_I) && mem_ack && !reset;
      d_ready  = (state == BUSY_D) && mem_ack && !reset;
      if_rdata = if_ready ? mem_rdata : '0;
      d_rdata  = d_ready  ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a latency-programmable memory responder.
// Expected grants are queued as requests are driven and consumed as the arbiter issues them.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wmask;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } txn_t;

   txn_t exp_q[$];
   txn_t if_q[$];
   txn_t d_q[$];

   int vectors     = 0;
   int miscompares = 0;

   int busy_cyc  = 0;
   int cur_lat   = 0;
   int fixed_lat = 0;
   bit rand_lat  = 1'b0;
   bit force_ack = 1'b0;

   mem_arbiter #(
      .ADDR_W       (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wmask   (d_wmask),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h0000_0513;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory responder: acks cur_lat cycles after mem_req rises; garbage read data otherwise.
   always @(negedge clk) begin
      if (mem_req === 1'b1) begin
         if (busy_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(0, 7)) : fixed_lat;
         if (busy_cyc == cur_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_model(mem_addr);
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
         busy_cyc++;
      end else begin
         busy_cyc  = 0;
         mem_ack   = force_ack;
         mem_rdata = force_ack ? 32'hCAFE_0001 : 32'h0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
      tick();
      tick();
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
      vectors++;
      if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
      vectors++;
      if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
      vectors++;
      if (mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      vectors++;
      if (mem_wmask !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wmask: got %h want 0", mem_wmask); end
      vectors++;
      if ({if_ready, d_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 00", {if_ready, d_ready}); end
      vectors++;
      if (dut.state !== IDLE) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want 0", dut.state); end
      vectors++;
      if (dut.u_starve.cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_starve: got %0d want 0", dut.u_starve.cnt); end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      bit seen = 1'b0;
      int pulses = 0;
      fixed_lat = 2;
      if_addr = 32'h0000_0010;
      if_req  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (mem_req && !seen) begin
            seen = 1'b1;
            vectors++;
            if (c != 1) begin miscompares++; $display("[TB] FAIL fetch_req_latency: got cycle %0d want 1", c); end
            vectors++;
            if ({mem_we, mem_wmask, mem_addr} !== {1'b0, 4'h0, 32'h10}) begin
               miscompares++;
               $display("[TB] FAIL fetch_fields: got we=%b mask=%h addr=%h want 0/0/00000010", mem_we, mem_wmask, mem_addr);
            end
         end
         vectors++;
         if (d_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fetch_d_ready: got %b want 0", d_ready); end
         if (if_ready === 1'b1) begin
            pulses++;
            vectors++;
            if (if_rdata !== 32'h0000_0513) begin miscompares++; $display("[TB] FAIL fetch_rdata: got %h want 00000513", if_rdata); end
            vectors++;
            if (c != 3) begin miscompares++; $display("[TB] FAIL fetch_ready_cycle: got %0d want 3", c); end
            if_req = 1'b0;
         end else begin
            vectors++;
            if (if_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL fetch_rdata_idle: got %h want 0", if_rdata); end
         end
      end
      vectors++;
      if (pulses != 1 || !seen) begin miscompares++; $display("[TB] FAIL fetch_pulses: got %0d pulses (req seen %b) want 1", pulses, seen); end
   endtask

   task automatic test_priority();
      txn_t e;
      bit   prev = 1'b0;
      int   grants = 0;
      int   last_rdy = -10;
      fixed_lat = 1;
      exp_q.delete();
      exp_q.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF, mask: 4'hF});
      exp_q.push_back('{we: 1'b0, addr: 32'h10,  wdata: 32'h0,         mask: 4'h0});
      d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
      if_addr = 32'h10;
      d_req = 1'b1; if_req = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (mem_req && !prev) begin
            grants++;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL priority_extra_grant: got grant at addr %h want none", mem_addr);
            end else begin
               e = exp_q.pop_front();
               vectors++;
               if ({mem_we, mem_addr, mem_wmask} !== {e.we, e.addr, e.mask} || (e.we && mem_wdata !== e.wdata)) begin
                  miscompares++;
                  $display("[TB] FAIL priority_grant%0d: got we=%b addr=%h wd=%h m=%h want we=%b addr=%h wd=%h m=%h",
                           grants, mem_we, mem_addr, mem_wdata, mem_wmask, e.we, e.addr, e.wdata, e.mask);
               end
               if (grants == 2) begin
                  vectors++;
                  if (c - last_rdy != 2) begin miscompares++; $display("[TB] FAIL priority_turnaround: got %0d cycles want 2", c - last_rdy); end
               end
            end
         end
         prev = mem_req;
         if (d_ready === 1'b1) begin
            last_rdy = c;
            d_req = 1'b0;
            vectors++;
            if (grants != 1) begin miscompares++; $display("[TB] FAIL priority_d_first: got d_ready at grant %0d want 1", grants); end
         end
         if (if_ready === 1'b1) begin
            last_rdy = c;
            if_req = 1'b0;
            vectors++;
            if (if_rdata !== 32'h0000_0513) begin miscompares++; $display("[TB] FAIL priority_if_rdata: got %h want 00000513", if_rdata); end
         end
      end
      vectors++;
      if (grants != 2 || exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL priority_count: got %0d grants want 2", grants); end
   endtask

   task automatic test_starvation();
      txn_t e;
      bit   prev = 1'b0;
      bit   done = 1'b0;
      int   grants = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fixed_lat = 0;
      exp_q.delete();
      for (int k = 0; k < 15; k++) begin
         if (k % 5 == 4) exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, mask: 4'h0});
         else            exp_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, mask: 4'h0});
      end
      if_addr = 32'h200;
      d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0; d_wmask = 4'h0;
      if_req = 1'b1; d_req = 1'b1;
      for (int c = 1; c <= 100 && !done; c++) begin
         tick();
         if (mem_req && !prev) begin
            grants++;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL starve_extra_grant: got grant at addr %h want none", mem_addr);
            end else begin
               e = exp_q.pop_front();
               vectors++;
               if ({mem_we, mem_addr, mem_wmask} !== {e.we, e.addr, e.mask}) begin
                  miscompares++;
                  $display("[TB] FAIL starve_grant%0d: got addr %h want %h", grants, mem_addr, e.addr);
               end
            end
         end
         prev = mem_req;
         if (d_ready === 1'b1) begin
            vectors++;
            if (d_rdata !== mem_model(32'h300)) begin miscompares++; $display("[TB] FAIL starve_d_rdata: got %h want %h", d_rdata, mem_model(32'h300)); end
         end
         if (if_ready === 1'b1) begin
            vectors++;
            if (if_rdata !== mem_model(32'h200)) begin miscompares++; $display("[TB] FAIL starve_if_rdata: got %h want %h", if_rdata, mem_model(32'h200)); end
            if (grants == 15) done = 1'b1;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) tick();
      vectors++;
      if (!done || exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL starve_sequence: got %0d grants done=%b want 15 ending in fetch", grants, done); end
   endtask

   task automatic test_reset_mid();
      bit stray = 1'b0;
      fixed_lat = 5;
      if_addr = 32'h40;
      d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234; d_wmask = 4'h3;
      if_req = 1'b1; d_req = 1'b1;
      tick();
      vectors++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h80}) begin
         miscompares++;
         $display("[TB] FAIL midreset_grant: got req=%b we=%b addr=%h want 1/1/00000080", mem_req, mem_we, mem_addr);
      end
      vectors++;
      if (dut.u_starve.cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL midreset_starve_inc: got %0d want 1", dut.u_starve.cnt); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_mem_req: got %b want 0", mem_req); end
      vectors++;
      if (dut.state !== IDLE) begin miscompares++; $display("[TB] FAIL midreset_state: got %0d want 0", dut.state); end
      vectors++;
      if (dut.u_starve.cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL midreset_starve: got %0d want 0", dut.u_starve.cnt); end
      if_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (d_ready !== 1'b0 || if_ready !== 1'b0 || mem_req !== 1'b0) stray = 1'b1;
      end
      vectors++;
      if (stray) begin miscompares++; $display("[TB] FAIL midreset_stray: got activity after reset want none"); end
   endtask

   task automatic test_idle_ack();
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      vectors++;
      if ({if_ready, d_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL idleack_ready: got %b want 00", {if_ready, d_ready}); end
      vectors++;
      if ({if_rdata, d_rdata} !== 64'h0) begin miscompares++; $display("[TB] FAIL idleack_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
      tick();
      vectors++;
      if (dut.state !== IDLE || mem_req !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idleack_state: got state=%0d req=%b want 0/0", dut.state, mem_req);
      end
   endtask

   task automatic test_random();
      localparam int NF = 30;
      localparam int ND = 30;
      txn_t        e;
      txn_t        snap;
      logic [31:0] r;
      bit          prev = 1'b0;
      bit          cur_is_d = 1'b0;
      int          if_issued = 0, d_issued = 0, if_done = 0, d_done = 0;
      rand_lat = 1'b1;
      if_q.delete();
      d_q.delete();
      for (int c = 0; c < 3000 && (if_done < NF || d_done < ND); c++) begin
         tick();
         if (mem_req && !prev) begin
            cur_is_d = mem_addr[31];
            snap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, mask: mem_wmask};
            vectors++;
            if (cur_is_d) begin
               if (d_q.size() == 0 || {mem_we, mem_addr, mem_wdata, mem_wmask} !== {d_q[0].we, d_q[0].addr, d_q[0].wdata, d_q[0].mask}) begin
                  miscompares++;
                  $display("[TB] FAIL random_d_grant: got we=%b addr=%h wd=%h m=%h want pending data request (%0d queued)",
                           mem_we, mem_addr, mem_wdata, mem_wmask, d_q.size());
               end
            end else begin
               if (if_q.size() == 0 || {mem_we, mem_addr, mem_wmask} !== {1'b0, if_q[0].addr, 4'h0}) begin
                  miscompares++;
                  $display("[TB] FAIL random_if_grant: got we=%b addr=%h m=%h want pending fetch (%0d queued)", mem_we, mem_addr, mem_wmask, if_q.size());
               end
            end
         end else if (mem_req) begin
            vectors++;
            if ({mem_we, mem_addr, mem_wdata, mem_wmask} !== {snap.we, snap.addr, snap.wdata, snap.mask}) begin
               miscompares++;
               $display("[TB] FAIL random_stable: got addr %h wd %h want addr %h wd %h", mem_addr, mem_wdata, snap.addr, snap.wdata);
            end
         end
         prev = mem_req;
         vectors++;
         if ((!if_ready && if_rdata !== 32'h0) || (!d_ready && d_rdata !== 32'h0)) begin
            miscompares++;
            $display("[TB] FAIL random_rdata_idle: got %h/%h want 0 when not ready", if_rdata, d_rdata);
         end
         if (if_ready === 1'b1) begin
            vectors++;
            if (if_q.size() == 0 || cur_is_d) begin
               miscompares++;
               $display("[TB] FAIL random_if_ready: got unexpected fetch completion (%0d queued)", if_q.size());
            end else begin
               e = if_q.pop_front();
               if (if_rdata !== mem_model(e.addr)) begin
                  miscompares++;
                  $display("[TB] FAIL random_if_rdata: got %h want %h", if_rdata, mem_model(e.addr));
               end
            end
            if_done++;
            if_req = 1'b0;
         end
         if (d_ready === 1'b1) begin
            vectors++;
            if (d_q.size() == 0 || !cur_is_d) begin
               miscompares++;
               $display("[TB] FAIL random_d_ready: got unexpected data completion (%0d queued)", d_q.size());
            end else begin
               e = d_q.pop_front();
               if (!e.we && d_rdata !== mem_model(e.addr)) begin
                  miscompares++;
                  $display("[TB] FAIL random_d_rdata: got %h want %h", d_rdata, mem_model(e.addr));
               end
            end
            d_done++;
            d_req = 1'b0;
         end
         if (!if_req && if_issued < NF && $urandom_range(0, 1) == 1) begin
            r = $urandom;
            if_addr = {1'b0, r[30:2], 2'b00};
            if_q.push_back('{we: 1'b0, addr: if_addr, wdata: 32'h0, mask: 4'h0});
            if_req = 1'b1;
            if_issued++;
         end
         if (!d_req && d_issued < ND && $urandom_range(0, 1) == 1) begin
            r = $urandom;
            d_addr  = {1'b1, r[30:2], 2'b00};
            d_we    = r[0];
            d_wdata = $urandom;
            d_wmask = r[7:4];
            d_q.push_back('{we: d_we, addr: d_addr, wdata: d_wdata, mask: d_wmask});
            d_req = 1'b1;
            d_issued++;
         end
      end
      rand_lat = 1'b0;
      if_req = 1'b0; d_req = 1'b0;
      vectors++;
      if (if_done != NF || d_done != ND || if_q.size() != 0 || d_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL random_completion: got %0d fetch %0d data done want %0d %0d", if_done, d_done, NF, ND);
      end
   endtask

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      test_reset();
      test_fetch();
      test_priority();
      test_starvation();
      test_reset_mid();
      test_idle_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
